muldiv_issue_queue: RTL
=======================

# muldiv_issue_queue

Multi-entry, out-of-order issue queue for the RV64M multiply/divide pipe. Sits between dispatch and the mul/div execute unit. Holds up to `DEPTH` decoded M-extension ops and tracks operand readiness against the write-back log each cycle. Each cycle it selects the oldest entry whose operands are ready and registers it toward the execute unit. Unlike a single-FIFO-head issue stage, a younger independent op may issue past an older op that is still stalled on a RAW hazard.

## Interface
Parameters:
- `RP`, 4 — physical copies per architectural register; `RB = $clog2(RP)`.
- `DEPTH`, 4 — queue entries; power of two, 2..16.
- `DW`, `13+3*(5+RB)` — issue-info width.
- `EXE_DW`, `DW` — execute-parameter width, equal to `DW`.

Ports:
- `CLK` in 1 — single clock, rising edge.
- `RSTn` in 1 — asynchronous, active-low reset.
- `enq_valid` in 1 — dispatch presents an op.
- `enq_ready` out 1 — queue can accept an op.
- `enq_info` in DW — packed op, MSB first:
  - 13 one-hot op bits, in order mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw;
  - then `rd0`, `rs1`, `rs2`, each `5+RB` bits as {arch[4:0], copy[RB-1:0]}.
- `mul_execute_ready` in 1 — execute unit can accept an op this cycle.
- `mul_exeparam_vaild_qout` out 1 — registered issue strobe.
- `mul_exeparam_qout` out EXE_DW — registered issued op.
- `wbLog_qout` in 32*RP — bit `p` set means physical register `p` has been written back.
- `flush` in 1 — pipeline flush.

## Operation
- Storage is a compacting array `ent[0..DEPTH-1]` with `vld[]`. `ent[0]` is the oldest entry; valid entries are contiguous from index 0. `cnt` holds the number of valid entries.
- Operand ready: `rsX_rdy = wbLog_qout[rsX] | (rsX[RB+:5]==0)`. Recomputed combinationally every cycle from the stored tag; no wakeup state is kept.
- Entry eligible: `vld[i] & (|op[12:0]) & rs1_rdy & rs2_rdy`. An entry with an all-zero op field is never eligible and blocks nothing except its own slot.
- Select: the lowest eligible index `k` (oldest first).
- Issue condition: `iss = ~flush & mul_execute_ready & any_eligible`.
- `mul_exeparam_vaild_qout <= iss`.
- `mul_exeparam_qout <= ent[k]` when `iss`; otherwise it holds its previous value.
- On issue of entry k, entries k+1.. shift down by one and `cnt` decrements.
- `enq_ready = (cnt != DEPTH)`. It is based on the registered count; a same-cycle issue does not grant credit.
- Enqueue (`enq_valid & enq_ready & ~flush`) writes slot `cnt` after any compaction, i.e. `cnt-1` if an issue occurs in the same cycle.
- Simultaneous enqueue and issue leaves `cnt` unchanged.
- A newly enqueued entry is not selectable in its enqueue cycle (no bypass build).
- On `flush`: all `vld` and `cnt` clear at the next edge, `mul_exeparam_vaild_qout <= 0`, and any enqueue that cycle is dropped. The payload register holds its value.
- Reset values:
  - `vld` = 0, `cnt` = 0;
  - `mul_exeparam_vaild_qout` = 0;
  - `mul_exeparam_qout` = 0;
  - therefore `enq_ready` = 1 out of reset.

## Timing
- Enqueue at edge t0. Entry is selectable in cycle t0+1. Issue strobe is high after edge t0+2, giving 2-cycle minimum latency.
- Issue output is registered and asserts for exactly one cycle per issued op.
- Back-to-back issue: one op per cycle while ops are eligible and `mul_execute_ready` = 1.
- `mul_execute_ready` is sampled in the same cycle as selection. The block does not hold or retry; the execute unit must accept any op strobed after a ready cycle.
- Full: with `cnt == DEPTH`, `enq_ready` = 0 even if an issue occurs in that cycle. `enq_ready` rises the cycle after the issue.
- Reset asserted mid-operation empties the queue asynchronously and forces the strobe low immediately.

## Configuration
- `MULDIV_ISSUE_BYPASS_EN` defined:
  - When the queue has no eligible entry, and the incoming enqueued op is eligible, and `mul_execute_ready` = 1 (and no flush), that op is issued directly into the output register in its enqueue cycle, bypassing storage.
  - It is not written into the queue. Latency becomes 1 cycle.
- Undefined: no bypass path; minimum latency is 2 cycles as specified above.

## Test plan
Bench parameters: `RP`=4, `DEPTH`=4.
- Reset, then enqueue a mul with rs1=7'h0C, rs2=7'h10 and both wbLog bits set, with `mul_execute_ready`=1 → strobe high 2 cycles after enqueue; `mul_exeparam_qout` equals the enqueued info.
- Enqueue A (div, rs1=7'h14 not written), then B (mul, ready operands) → B issues first. Set `wbLog[20]` → A issues on the next select cycle.
- Enqueue 4 stalled ops → `enq_ready`=0. Wake entry 2 → it issues, entries 3→2 compact, and `enq_ready`=1 one cycle later.
- Assert `flush` together with an enqueue while 3 entries are valid and one is eligible → no strobe, `cnt`=0, dropped op never issues.
- rs1 arch=x0 with copy=2 and wbLog clear → treated as ready and issues.
- `MULDIV_ISSUE_BYPASS_EN` defined, empty queue, ready op enqueued with `mul_execute_ready`=1 → strobe after 1 cycle and `cnt` stays 0; same op with `mul_execute_ready`=0 → stored and `cnt`=1.

Source files
------------

// File: rtl/muldiv_issue_queue.sv
// Out-of-order issue queue for the RV64M multiply/divide pipe: oldest-ready select with compaction.
// Optional build macro MULDIV_ISSUE_BYPASS_EN adds a direct enqueue-to-issue path when nothing is eligible.
module muldiv_issue_queue #(
   parameter int RP     = 4,
   parameter int DEPTH  = 4,
   parameter int RB     = $clog2(RP),
   parameter int DW     = 13 + 3 * (5 + RB),
   parameter int EXE_DW = DW
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [DW-1:0]     enq_info,
   input  logic              mul_execute_ready,
   output logic              mul_exeparam_vaild_qout,
   output logic [EXE_DW-1:0] mul_exeparam_qout,
   input  logic [32*RP-1:0]  wbLog_qout,
   input  logic              flush
);

   localparam int TW = 5 + RB;
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] ent   [DEPTH];
   logic [DW-1:0] ent_n [DEPTH];
   logic [DEPTH-1:0] vld, vld_n, elig;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] sel_idx, wr_idx;
   logic          any_elig, iss, enq_fire, enq_write, out_fire;
   logic [DW-1:0] out_data;

   // Architectural x0 is always readable, so its tag never waits on write-back.
   function automatic logic op_eligible(input logic [DW-1:0] e, input logic [32*RP-1:0] wb);
      logic [TW-1:0] s1;
      logic [TW-1:0] s2;
      s1 = e[TW +: TW];
      s2 = e[0 +: TW];
      return (|e[DW-1 -: 13]) & (wb[s1] | (s1[RB +: 5] == 5'd0))
                              & (wb[s2] | (s2[RB +: 5] == 5'd0));
   endfunction

   always_comb begin
      elig    = '0;
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         elig[i] = vld[i] & op_eligible(ent[i], wbLog_qout);
      for (int i = DEPTH - 1; i >= 0; i--)
         if (elig[i]) sel_idx = IW'(i);
      any_elig = |elig;
   end

   assign enq_ready = (cnt != CW'(DEPTH));
   assign iss       = ~flush & mul_execute_ready & any_elig;
   assign enq_fire  = enq_valid & enq_ready & ~flush;

`ifdef MULDIV_ISSUE_BYPASS_EN
   logic bypass;
   assign bypass    = enq_fire & ~any_elig & mul_execute_ready & op_eligible(enq_info, wbLog_qout);
   assign enq_write = enq_fire & ~bypass;
   assign out_fire  = iss | bypass;
   assign out_data  = bypass ? enq_info : ent[sel_idx];
`else
   assign enq_write = enq_fire;
   assign out_fire  = iss;
   assign out_data  = ent[sel_idx];
`endif

   // The write slot is taken after compaction, so a same-cycle issue pulls it down by one.
   always_comb begin
      ent_n  = ent;
      vld_n  = vld;
      cnt_n  = cnt;
      wr_idx = iss ? IW'(cnt - CW'(1)) : IW'(cnt);
      if (iss) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(sel_idx)) begin
               ent_n[i] = ent[i+1];
               vld_n[i] = vld[i+1];
            end
         end
         vld_n[DEPTH-1] = 1'b0;
         cnt_n = cnt - CW'(1);
      end
      if (enq_write) begin
         ent_n[wr_idx] = enq_info;
         vld_n[wr_idx] = 1'b1;
         cnt_n         = cnt_n + CW'(1);
      end
      if (flush) begin
         vld_n = '0;
         cnt_n = '0;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         vld <= '0;
         cnt <= '0;
      end else begin
         ent <= ent_n;
         vld <= vld_n;
         cnt <= cnt_n;
      end
   end

   // Payload only moves on an issue; flush clears the strobe but leaves the last payload visible.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         mul_exeparam_vaild_qout <= 1'b0;
         mul_exeparam_qout       <= '0;
      end else begin
         mul_exeparam_vaild_qout <= out_fire;
         if (out_fire) mul_exeparam_qout <= EXE_DW'(out_data);
      end
   end

endmodule
